cla: RTL and testbench

CLA -- requirements
Module: cla

---
 rtl/cla_pkg.sv | 18 +
 rtl/cla_if.sv | 31 +++
 rtl/cla_group4.sv | 38 +++
 rtl/cla.sv | 115 +++++++++++
 tb/tb_cla.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg -- shared constants and helpers for the carry-lookahead adder.
//   GROUP_WIDTH : bits handled by one first-level lookahead group (fixed at 4)
//   MIN_WIDTH / MAX_WIDTH : supported operand width range
//   num_groups(): number of 4-bit groups for a given operand width
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam int GROUP_WIDTH = 4;
  localparam int MIN_WIDTH   = 4;
  localparam int MAX_WIDTH   = 64;

  // Operand widths are whole multiples of GROUP_WIDTH, so this divides exactly.
  function automatic int num_groups(input int width);
    return width / GROUP_WIDTH;
  endfunction

endpackage : cla_pkg

// File: rtl/cla_if.sv
// -----------------------------------------------------------------------------
// cla_if -- signal bundle for driving and observing a cla instance.
//   a, b, carry_in, in_valid : operand side (driven by the master)
//   sum, carry_out, out_valid: registered result side (driven by the adder)
// Modports:
//   master : the operand source / result consumer
//   slave  : the adder side
// -----------------------------------------------------------------------------
interface cla_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             out_valid;

  modport master (
    output a, b, carry_in, in_valid,
    input  sum, carry_out, out_valid
  );

  modport slave (
    input  a, b, carry_in, in_valid,
    output sum, carry_out, out_valid
  );

endinterface : cla_if

// File: rtl/cla_group4.sv
// -----------------------------------------------------------------------------
// cla_group4 -- first-level 4-bit carry-lookahead block.
//   p[3:0], g[3:0] : bit propagate / generate of the four bits in this group
//   cin            : carry into bit 0 of the group
//   c[3:0]         : carry into each bit of the group (c[0] == cin)
//   group_p        : group propagate (all four bits propagate)
//   group_g        : group generate (group produces a carry on its own)
// All carries are flattened sum-of-products; nothing ripples bit to bit.
// -----------------------------------------------------------------------------
module cla_group4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:0] c,
  output logic       group_p,
  output logic       group_g
);

  // Separate continuous assigns keep group_p/group_g independent of cin, so
  // the second-level unit reading them does not form a false loop through cin.
  assign c[0] = cin;
  assign c[1] = g[0]
              | (p[0] & cin);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign group_p = &p;
  assign group_g = g[3]
                 | (p[3] & g[2])
                 | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

endmodule : cla_group4

// File: rtl/cla.sv
// -----------------------------------------------------------------------------
// cla -- registered two-level carry-lookahead adder.
//   {carry_out, sum} = a + b + carry_in, one cycle after the operands are
//   sampled. Full throughput, no backpressure.
// Parameters:
//   WIDTH     : operand width, a multiple of 4 in 4..64
// Ports:
//   clk       : clock, all state on rising edge
//   rst_n     : synchronous active-low reset, clears all outputs
//   a, b      : unsigned operands
//   carry_in  : carry into bit 0
//   in_valid  : operands are valid this cycle
//   sum       : registered sum
//   carry_out : registered carry out of the MSB
//   out_valid : in_valid delayed by one cycle
// -----------------------------------------------------------------------------
module cla
  import cla_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             out_valid
);

  localparam int NG = num_groups(WIDTH);

  logic [WIDTH-1:0] bit_p;
  logic [WIDTH-1:0] bit_g;
  logic [WIDTH-1:0] bit_c;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [NG:0]      grp_c;     // grp_c[k] = carry into group k, grp_c[NG] = MSB carry

  logic [WIDTH-1:0] sum_d,       sum_q;
  logic             carry_out_d, carry_out_q;
  logic             out_valid_d, out_valid_q;

  assign bit_p = a ^ b;
  assign bit_g = a & b;

  // First level: one lookahead block per 4-bit group.
  for (genvar gi = 0; gi < NG; gi++) begin : g_group
    cla_group4 u_group (
      .p       (bit_p[gi*GROUP_WIDTH +: GROUP_WIDTH]),
      .g       (bit_g[gi*GROUP_WIDTH +: GROUP_WIDTH]),
      .cin     (grp_c[gi]),
      .c       (bit_c[gi*GROUP_WIDTH +: GROUP_WIDTH]),
      .group_p (grp_p[gi]),
      .group_g (grp_g[gi])
    );
  end

  // Second level: each group carry is expanded into its full sum-of-products
  //   grp_c[k+1] = OR_j ( G_j & P_{j+1..k} )  |  ( P_{0..k} & carry_in )
  // The loops only unroll the expression; no term depends on another carry.
  always_comb begin
    logic carry;
    logic term;
    carry    = 1'b0;
    term     = 1'b0;
    grp_c    = '0;
    grp_c[0] = carry_in;
    for (int k = 0; k < NG; k++) begin
      carry = 1'b0;
      for (int j = 0; j <= k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m <= k; m++) begin
          term = term & grp_p[m];
        end
        carry = carry | term;
      end
      term = carry_in;
      for (int m = 0; m <= k; m++) begin
        term = term & grp_p[m];
      end
      grp_c[k+1] = carry | term;
    end
  end

  // Result is loaded every cycle; out_valid alone says whether it is meaningful.
  always_comb begin
    sum_d       = bit_p ^ bit_c;
    carry_out_d = grp_c[NG];
    out_valid_d = in_valid;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of statement order.
  // NOTE: reset is checked first inside the clocked block, so it overrides the
  // operands presented on the same edge and their result is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign out_valid = out_valid_q;

endmodule : cla

// File: tb/tb_cla.sv
// -----------------------------------------------------------------------------
// tb_cla -- scoreboard bench for cla at WIDTH=4 (hand-computed vectors) and
// WIDTH=16 (random operands against an a+b+carry_in reference), both running
// in the same cycles. Stimulus pushes expectations at the falling edge; the
// monitors pop and compare shortly after each rising edge.
// -----------------------------------------------------------------------------
module tb_cla;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  cla_if #(.WIDTH(4))  if4 ();
  cla_if #(.WIDTH(16)) if16 ();

  cla #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (if4.a),
    .b         (if4.b),
    .carry_in  (if4.carry_in),
    .in_valid  (if4.in_valid),
    .sum       (if4.sum),
    .carry_out (if4.carry_out),
    .out_valid (if4.out_valid)
  );

  cla #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (if16.a),
    .b         (if16.b),
    .carry_in  (if16.carry_in),
    .in_valid  (if16.in_valid),
    .sum       (if16.sum),
    .carry_out (if16.carry_out),
    .out_valid (if16.out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected out_valid per cycle, and expected {carry_out,sum} per valid result.
  bit          vq4[$];
  logic [4:0]  rq4[$];
  bit          vq16[$];
  logic [16:0] rq16[$];

  int n16 = 0;   // count of scored 16-bit cycles, first few use corner operands

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge. When push is set, the
  // expected response is queued for the monitors.
  task automatic step(input logic rst, input logic [3:0] a4, input logic [3:0] b4,
                      input logic ci4, input logic v4, input logic [4:0] exp4,
                      input bit push);
    logic [15:0] a16;
    logic [15:0] b16;
    logic        ci16;
    logic        v16;
    @(negedge clk);
    rst_n = rst;
    a16  = 16'($urandom);
    b16  = 16'($urandom);
    ci16 = 1'($urandom);
    v16  = 1'($urandom);
    if (push) begin
      case (n16)
        0: begin a16 = 16'hffff; b16 = 16'hffff; ci16 = 1'b1; v16 = 1'b1; end
        1: begin a16 = 16'h0000; b16 = 16'h0000; ci16 = 1'b0; v16 = 1'b1; end
        2: begin a16 = 16'haaaa; b16 = 16'h5555; ci16 = 1'b1; v16 = 1'b1; end
        default: ;
      endcase
      n16++;
    end
    if4.a         = a4;
    if4.b         = b4;
    if4.carry_in  = ci4;
    if4.in_valid  = v4;
    if16.a        = a16;
    if16.b        = b16;
    if16.carry_in = ci16;
    if16.in_valid = v16;
    if (push) begin
      vq4.push_back(v4);
      if (v4) rq4.push_back(exp4);
      vq16.push_back(v16);
      if (v16) rq16.push_back({1'b0, a16} + {1'b0, b16} + 17'(ci16));
    end
  endtask

  // Monitors: sample 1 time unit after each rising edge.
  initial begin
    bit         ev;
    logic [4:0] er;
    forever begin
      @(posedge clk);
      #1;
      if (vq4.size() > 0) begin
        ev = vq4.pop_front();
        check("w4 out_valid", 64'(if4.out_valid), 64'(ev));
      end
      if (if4.out_valid === 1'b1) begin
        if (rq4.size() == 0) begin
          check("w4 unexpected result", 64'(1), 64'(0));
        end else begin
          er = rq4.pop_front();
          check("w4 {carry_out,sum}", 64'({if4.carry_out, if4.sum}), 64'(er));
        end
      end
    end
  end

  initial begin
    bit          ev;
    logic [16:0] er;
    forever begin
      @(posedge clk);
      #1;
      if (vq16.size() > 0) begin
        ev = vq16.pop_front();
        check("w16 out_valid", 64'(if16.out_valid), 64'(ev));
      end
      if (if16.out_valid === 1'b1) begin
        if (rq16.size() == 0) begin
          check("w16 unexpected result", 64'(1), 64'(0));
        end else begin
          er = rq16.pop_front();
          check("w16 {carry_out,sum}", 64'({if16.carry_out, if16.sum}), 64'(er));
        end
      end
    end
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic       v;
    logic [4:0] exp;   // hand-computed {carry_out, sum}
  } vec4_t;

  localparam int NV = 12;
  vec4_t tbl[NV];

  task automatic reset_checks(input string tag);
    @(posedge clk);
    #2;
    check({tag, " w4 sum"},        64'(if4.sum),        64'(0));
    check({tag, " w4 carry_out"},  64'(if4.carry_out),  64'(0));
    check({tag, " w4 out_valid"},  64'(if4.out_valid),  64'(0));
    check({tag, " w16 sum"},       64'(if16.sum),       64'(0));
    check({tag, " w16 carry_out"}, 64'(if16.carry_out), 64'(0));
    check({tag, " w16 out_valid"}, 64'(if16.out_valid), 64'(0));
  endtask

  initial begin
    tbl = '{
      '{4'b0010, 4'b0100, 1'b1, 1'b1, 5'b0_0111},
      '{4'b0110, 4'b0001, 1'b1, 1'b1, 5'b0_1000},
      '{4'b0011, 4'b1101, 1'b1, 1'b1, 5'b1_0001},
      '{4'b0001, 4'b0001, 1'b1, 1'b1, 5'b0_0011},
      '{4'b1111, 4'b0000, 1'b1, 1'b1, 5'b1_0000},
      '{4'b1111, 4'b1111, 1'b1, 1'b1, 5'b1_1111},
      '{4'b0000, 4'b0000, 1'b0, 1'b1, 5'b0_0000},
      '{4'b1010, 4'b0101, 1'b1, 1'b1, 5'b1_0000},
      '{4'b0111, 4'b0111, 1'b0, 1'b0, 5'b0_1110},
      '{4'b1001, 4'b0011, 1'b0, 1'b1, 5'b0_1100},
      '{4'b1000, 4'b1000, 1'b0, 1'b1, 5'b1_0000},
      '{4'b0101, 4'b0110, 1'b0, 1'b0, 5'b0_1011}
    };

    rst_n         = 1'b0;
    if4.a         = '0;
    if4.b         = '0;
    if4.carry_in  = 1'b0;
    if4.in_valid  = 1'b0;
    if16.a        = '0;
    if16.b        = '0;
    if16.carry_in = 1'b0;
    if16.in_valid = 1'b0;

    // Reset held with all-ones operands presented: outputs must stay cleared.
    step(1'b0, 4'hf, 4'hf, 1'b1, 1'b1, 5'h00, 1'b0);
    step(1'b0, 4'hf, 4'hf, 1'b1, 1'b1, 5'h00, 1'b0);
    reset_checks("init reset");

    // First edge out of reset must already produce a correct result.
    for (int i = 0; i < NV; i++) begin
      step(1'b1, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].v, tbl[i].exp, 1'b1);
    end

    // Reset mid-stream overrides the operands of that cycle.
    step(1'b0, 4'hf, 4'hf, 1'b1, 1'b1, 5'h00, 1'b0);
    reset_checks("mid reset");
    step(1'b1, 4'hf, 4'hf, 1'b1, 1'b1, 5'b1_1111, 1'b1);

    // Back-to-back traffic: 4-bit table replayed, 16-bit random operands.
    for (int i = 0; i < 150; i++) begin
      step(1'b1, tbl[i % NV].a, tbl[i % NV].b, tbl[i % NV].ci, tbl[i % NV].v,
           tbl[i % NV].exp, 1'b1);
    end

    // Drain: one idle scored cycle, then confirm every expectation was consumed.
    step(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 5'h00, 1'b0);
    @(posedge clk);
    #3;
    check("w4 results left",  64'(rq4.size()),  64'(0));
    check("w16 results left", 64'(rq16.size()), 64'(0));
    check("w4 valids left",   64'(vq4.size()),  64'(0));
    check("w16 valids left",  64'(vq16.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cla
